// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: FSM states, grant encoding
// and the byte-to-word address shift.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;
    localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: on a tie the port not granted last wins.
// last_grant only moves when the owning transaction completes (update strobe).
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   update,
    input  grant_t upd_grant,
    output grant_t grant
);

    grant_t last_grant_reg;

    // Resetting to GNT_I lets the data port win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= GNT_I;
        end else if (update) begin
            last_grant_reg <= upd_grant;
        end
    end

    always_comb begin
        grant = GNT_I;
        if (req_i && req_d) begin
            grant = (last_grant_reg == GNT_I) ? GNT_D : GNT_I;
        end else if (req_d) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM between the instruction-fetch and load/store ports of the core,
// sequencing cs/we/oe around ram_done with a watchdog for a RAM that never answers.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_done,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg;
    grant_t            gnt_reg;
    grant_t            grant;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_din_reg;
    logic              ram_cs_reg;
    logic              ram_we_reg;
    logic              ram_oe_reg;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              i_done_reg;
    logic              d_done_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              arb_update;

    assign arb_update = (state_reg == BUSY) && ram_done;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (i_req),
        .req_d     (d_req),
        .update    (arb_update),
        .upd_grant (gnt_reg),
        .grant     (grant)
    );

    // The I port is read-only, so a write can only come from a D grant.
    always_comb begin
        sel_addr = (grant == GNT_D) ? d_addr : i_addr;
        sel_we   = (grant == GNT_D) && d_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= GNT_I;
            cnt_reg      <= '0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            ram_cs_reg   <= 1'b0;
            ram_we_reg   <= 1'b0;
            ram_oe_reg   <= 1'b0;
            i_rdata_reg  <= '0;
            d_rdata_reg  <= '0;
            i_done_reg   <= 1'b0;
            d_done_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            i_done_reg <= 1'b0;
            d_done_reg <= 1'b0;
            err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_req || d_req) begin
                        gnt_reg      <= grant;
                        ram_addr_reg <= sel_addr >> WORD_SHIFT;
                        ram_din_reg  <= d_wdata;
                        ram_cs_reg   <= 1'b1;
                        ram_we_reg   <= sel_we;
                        ram_oe_reg   <= !sel_we;
                        cnt_reg      <= '0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (ram_done) begin
                        if (!ram_we_reg) begin
                            if (gnt_reg == GNT_D) begin
                                d_rdata_reg <= ram_dout;
                            end else begin
                                i_rdata_reg <= ram_dout;
                            end
                        end
                        i_done_reg <= (gnt_reg == GNT_I);
                        d_done_reg <= (gnt_reg == GNT_D);
                        ram_cs_reg <= 1'b0;
                        ram_we_reg <= 1'b0;
                        ram_oe_reg <= 1'b0;
                        state_reg  <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Abort: complete the requester with err, leave rdata alone.
                        i_done_reg <= (gnt_reg == GNT_I);
                        d_done_reg <= (gnt_reg == GNT_D);
                        err_reg    <= 1'b1;
                        ram_cs_reg <= 1'b0;
                        ram_we_reg <= 1'b0;
                        ram_oe_reg <= 1'b0;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata  = i_rdata_reg;
    assign d_rdata  = d_rdata_reg;
    assign i_done   = i_done_reg;
    assign d_done   = d_done_reg;
    assign err      = err_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;
    assign ram_cs   = ram_cs_reg;
    assign ram_we   = ram_we_reg;
    assign ram_oe   = ram_oe_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences and a
// randomized two-requester run against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, ram_addr, ram_din, ram_dout;
    logic        i_done, d_done, err, ram_done, ram_cs, ram_we, ram_oe;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .err      (err),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_done (ram_done),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe)
    );

    // RAM model: answers ram_lat cycles after cs rises, or never when ram_never is set.
    logic [31:0] mem [0:255];
    int          busy_cnt  = 0;
    int          ram_lat   = 0;
    bit          ram_never = 1'b0;
    bit          mem_init  = 1'b1;

    assign ram_done = ram_cs && !ram_never && (busy_cnt == ram_lat);
    assign ram_dout = mem[ram_addr[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (ram_cs && ram_done && ram_we) begin
            mem[ram_addr[7:0]] <= ram_din;
        end
        busy_cnt <= ram_cs ? busy_cnt + 1 : 0;
    end

    // Reference model state.
    logic [31:0] sh [0:255];
    logic [31:0] m_rdata [2];
    int          m_last_g;
    int          grant_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    int          o_k;
    logic [31:0] o_rd, o_addr, o_din;
    logic        o_err, o_cs, o_we, o_oe, o_extra, o_wrong;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_word;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic fail_line(input string name, input string detail);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic drive(input int p, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            i_req  = req;
            i_addr = addr;
        end else begin
            d_req   = req;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        ram_never = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        m_last_g   = 0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    // One isolated transaction; observations land in the o_* variables.
    task automatic single_txn(input int p, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input bit never, input int drop_at);
        bit         got;
        logic [7:0] w;
        w = addr[9:2];
        @(negedge clk);
        ram_lat   = lat;
        ram_never = never;
        drive(p, 1, we, addr, wdata);
        o_k = -1; o_wrong = 1'b0; got = 1'b0;
        o_rd = 'x; o_err = 1'bx;
        for (int k = 1; k <= 200 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                o_cs = ram_cs; o_addr = ram_addr; o_we = ram_we; o_oe = ram_oe; o_din = ram_din;
            end
            if (k == drop_at) drive(p, 0, we, addr, wdata);
            if (p == 0 ? d_done : i_done) o_wrong = 1'b1;
            if (p == 0 ? i_done : d_done) begin
                got   = 1'b1;
                o_k   = k;
                o_rd  = (p == 0) ? i_rdata : d_rdata;
                o_err = err;
            end
        end
        drive(p, 0, we, addr, wdata);
        @(negedge clk);
        o_extra = i_done | d_done;
        if (got && !o_err) begin
            m_last_g = p;
            if (we) sh[w] = wdata;
            else    m_rdata[p] = sh[w];
        end
        $display("txn port=%s we=%0d addr=%08h lat=%0d done_at=%0d rdata=%08h err=%0b",
                 p ? "D" : "I", we, addr, lat, o_k, o_rd, o_err);
    endtask

    // Two free-running requesters; the model predicts winner and completion cycle.
    task automatic run_dual(input int n_i, input int n_d, input int max_gap, input int max_lat);
        int          left [2];
        int          gap [2];
        bit          pend [2];
        bit          op_we [2];
        logic [31:0] op_addr [2];
        logic [31:0] op_wd [2];
        bit          cur_v, ok_end;
        int          cur_p, cur_t, dec_t, free_at;
        logic [31:0] exp_rd;
        left[0] = n_i; left[1] = n_d;
        gap[0] = 0; gap[1] = 0; pend[0] = 0; pend[1] = 0;
        cur_v = 0; cur_p = 0; cur_t = 0; dec_t = 0; free_at = 0; ok_end = 0;
        grant_q.delete();
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (cur_v && t == dec_t + 1) begin
                chk("dual_busy_strobes", {ram_cs, ram_we, ram_oe, ram_addr},
                    {1'b1, op_we[cur_p], !op_we[cur_p], op_addr[cur_p] >> 2});
                if (op_we[cur_p]) chk("dual_ram_din", ram_din, op_wd[cur_p]);
            end
            for (int p = 0; p < 2; p++) begin
                if (p == 0 ? i_done : d_done) begin
                    if (!cur_v || cur_p != p || t != cur_t) begin
                        fail_line("dual_done_order", $sformatf(
                            "port %0d done at t=%0d, required port %0d at t=%0d (pending=%0b)",
                            p, t, cur_p, cur_t, cur_v));
                    end else begin
                        exp_rd = op_we[p] ? m_rdata[p] : sh[op_addr[p][9:2]];
                        chk("dual_rdata", (p == 0) ? i_rdata : d_rdata, exp_rd);
                        chk("dual_err_and_gap", {err, ram_cs}, 2'b00);
                        if (op_we[p]) sh[op_addr[p][9:2]] = op_wd[p];
                        else          m_rdata[p] = exp_rd;
                        m_last_g = p;
                        free_at  = t + 1;
                        cur_v    = 0;
                    end
                    $display("txn port=%s we=%0d addr=%08h done_t=%0d", p ? "D" : "I",
                             op_we[p], op_addr[p], t);
                    pend[p] = 0;
                    drive(p, 0, op_we[p], op_addr[p], op_wd[p]);
                    gap[p] = $urandom_range(max_gap, 0);
                end
            end
            if (cur_v && t > cur_t) begin
                fail_line("dual_done_missing", $sformatf("no done by t=%0d for port %0d", cur_t, cur_p));
                break;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && left[p] > 0) begin
                    if (gap[p] > 0) begin
                        gap[p]--;
                    end else begin
                        op_we[p]   = (p == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
                        op_addr[p] = 32'($urandom_range(1023, 0));
                        op_wd[p]   = $urandom;
                        pend[p]    = 1;
                        left[p]--;
                        drive(p, 1, op_we[p], op_addr[p], op_wd[p]);
                    end
                end
            end
            if (!cur_v && t >= free_at && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) cur_p = (m_last_g == 0) ? 1 : 0;
                else                    cur_p = pend[1] ? 1 : 0;
                ram_lat = $urandom_range(max_lat, 0);
                dec_t   = t;
                cur_t   = t + 2 + ram_lat;
                cur_v   = 1;
                grant_q.push_back(cur_p);
            end
            if (left[0] == 0 && left[1] == 0 && !pend[0] && !pend[1] && !cur_v) begin
                ok_end = 1;
                break;
            end
        end
        if (!ok_end) fail_line("dual_budget", "requesters did not drain within the cycle budget");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] held, exp_v;
        bit          bad;

        vecs[0] = '{1'b1, 1'b1, 32'h008, 32'hE3A0_1005, 0, 32'd2,    32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h008, 32'h0,         1, 32'd2,    32'hE3A0_1005};
        vecs[2] = '{1'b1, 1'b1, 32'h013, 32'h1234_5678, 2, 32'd4,    32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h010, 32'h0,         0, 32'd4,    32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h011, 32'h0,         3, 32'd4,    32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, 32'h3FC, 32'hA5A5_A5A5, 0, 32'hFF,   32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h3FE, 32'h0,         1, 32'hFF,   32'hA5A5_A5A5};
        vecs[7] = '{1'b0, 1'b0, 32'h01C, 32'h0,         0, 32'd7,    32'hC0DE_0007};

        for (int i = 0; i < 256; i++) sh[i] = 32'hC0DE_0000 + 32'(i);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        do_reset();
        mem_init = 1'b0;
        chk("reset_rdata", {i_rdata, d_rdata}, 64'h0);
        chk("reset_strobes", {i_done, d_done, err, ram_cs, ram_we, ram_oe}, 6'h0);
        chk("reset_ram_bus", {ram_addr, ram_din}, 64'h0);

        for (int v = 0; v < 8; v++) begin
            int p;
            p    = vecs[v].is_d ? 1 : 0;
            held = m_rdata[p];
            single_txn(p, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].lat, 1'b0, 0);
            chk($sformatf("v%0d_latency", v), 64'(o_k), 64'(vecs[v].lat + 2));
            chk($sformatf("v%0d_busy_strobes", v), {o_cs, o_we, o_oe}, {1'b1, vecs[v].we, !vecs[v].we});
            chk($sformatf("v%0d_ram_addr", v), o_addr, vecs[v].exp_word);
            if (vecs[v].we) chk($sformatf("v%0d_ram_din", v), o_din, vecs[v].wdata);
            chk($sformatf("v%0d_rdata", v), o_rd, vecs[v].we ? held : vecs[v].exp_rdata);
            chk($sformatf("v%0d_err", v), o_err, 1'b0);
            chk($sformatf("v%0d_single_done", v), {o_extra, o_wrong}, 2'b00);
        end

        single_txn(0, 1'b0, 32'h044, 32'h0, 3, 1'b0, 2);
        chk("drop_latency", 64'(o_k), 64'd5);
        chk("drop_rdata", o_rd, 32'hC0DE_0011);
        chk("drop_err_extra", {o_err, o_extra, o_wrong}, 3'b000);

        held = m_rdata[1];
        single_txn(1, 1'b0, 32'h020, 32'h0, 0, 1'b1, 0);
        chk("timeout_latency", 64'(o_k), 64'(TO + 1));
        chk("timeout_err", o_err, 1'b1);
        chk("timeout_rdata_held", o_rd, held);
        chk("timeout_cs_busy", o_cs, 1'b1);
        single_txn(1, 1'b0, 32'h020, 32'h0, 0, 1'b0, 0);
        chk("post_timeout_latency", 64'(o_k), 64'd2);
        chk("post_timeout_rdata", o_rd, 32'hC0DE_0008);
        chk("post_timeout_err", o_err, 1'b0);

        do_reset();
        run_dual(3, 3, 0, 0);
        chk("fair_count", 64'(grant_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair_grant%0d", i), 64'(grant_q.size() > i ? grant_q[i] : 9),
                64'((i % 2 == 0) ? 1 : 0));
        end

        run_dual(40, 40, 3, 3);

        @(negedge clk);
        ram_never = 1'b1;
        drive(1, 1, 0, 32'h030, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy_cs", ram_cs, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_strobes", {ram_cs, ram_we, ram_oe}, 3'b000);
        drive(1, 0, 0, 32'h030, 0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bad |= i_done | d_done;
        end
        chk("rst_no_done", bad, 1'b0);
        rst_n      = 1'b1;
        ram_never  = 1'b0;
        m_last_g   = 0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        chk("rst_release_outputs", {i_rdata, d_rdata, i_done, d_done, err, ram_cs}, 68'h0);
        exp_v = sh[12];
        single_txn(1, 1'b0, 32'h030, 32'h0, 0, 1'b0, 0);
        chk("rst_reissue_latency", 64'(o_k), 64'd2);
        chk("rst_reissue_rdata", o_rd, exp_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
